req_pending_tracker: RTL and testbench

REQ_PENDING_TRACKER -- requirements
Module: req_pending_tracker

---
 rtl/req_track_pkg.sv | 19 +
 rtl/req_pending_tracker_if.sv | 28 ++
 rtl/req_track_chan.sv | 82 ++++++++
 rtl/req_pending_tracker.sv | 75 +++++++
 tb/tb_req_pending_tracker.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/req_track_pkg.sv
// Shared defaults and types for the request pending tracker.
//   NUM_REQ_DEF  : default number of requester channels
//   CNT_W_DEF    : default pending-counter width per channel
//   PEND_MAX_DEF : default saturation value (2^CNT_W_DEF - 1)
//   pend_cnt_t   : pending counter type at the default width
//   pend_max()   : saturation value for an arbitrary counter width
package req_track_pkg;

  localparam int unsigned NUM_REQ_DEF  = 4;
  localparam int unsigned CNT_W_DEF    = 3;
  localparam int unsigned PEND_MAX_DEF = (1 << CNT_W_DEF) - 1;

  typedef logic [CNT_W_DEF-1:0] pend_cnt_t;

  function automatic int unsigned pend_max(input int unsigned cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/req_pending_tracker_if.sv
// Request/grant handshake between requesters, the tracker and the arbiter.
//   req_pulse : request events, one per set bit per cycle
//   gnt       : registered grant from the fixed-priority arbiter
//   req       : request vector presented to the arbiter
// master drives events and grants, slave is the tracker.
interface req_pending_tracker_if
  import req_track_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF
) ();

  logic [NUM_REQ-1:0] req_pulse;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] req;

  modport master (
    output req_pulse,
    output gnt,
    input  req
  );

  modport slave (
    input  req_pulse,
    input  gnt,
    output req
  );

endinterface

// File: rtl/req_track_chan.sv
// One tracker channel: saturating pending counter plus sticky error flags.
//   clk, rst   : clock, synchronous active-high reset
//   req_pulse  : new request event
//   gnt        : grant for this channel
//   err_clr    : clear sticky flags (a same-cycle set wins)
//   req        : pending count remaining after the current grant is nonzero
//   full       : counter at saturation
//   ovf_err    : sticky, request dropped on a full counter
//   gnt_err    : sticky, grant seen with nothing pending
//   gnt_taken  : grant consumed this cycle (only with REQ_TRACK_STATS_EN)
module req_track_chan
  import req_track_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req_pulse,
  input  logic gnt,
  input  logic err_clr,
  output logic req,
  output logic full,
  output logic ovf_err,
  output logic gnt_err
`ifdef REQ_TRACK_STATS_EN
  ,
  output logic gnt_taken
`endif
);

  localparam int unsigned PendMaxInt = pend_max(CNT_W);
  localparam logic [CNT_W-1:0] PendMax = PendMaxInt[CNT_W-1:0];
  localparam logic [CNT_W-1:0] PendOne = 1;

  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             gerr_q, gerr_d;
  logic             empty, at_max, take, drop, inc;

  always_comb begin
    empty  = (pend_q == '0);
    at_max = (pend_q == PendMax);
    take   = gnt & ~empty;
    // A grant in the same cycle frees a slot, so only drop when not granted.
    drop   = req_pulse & at_max & ~gnt;
    inc    = req_pulse & ~drop;

    pend_d = pend_q;
    if (inc && !take) begin
      pend_d = pend_q + PendOne;
    end else if (take && !inc) begin
      pend_d = pend_q - PendOne;
    end

    ovf_d  = drop | (ovf_q & ~err_clr);
    gerr_d = (gnt & empty) | (gerr_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
      gerr_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      gerr_q <= gerr_d;
    end
  end

  // Count left after this cycle's grant; hides the last request while it is
  // being granted so the registered arbiter cannot grant it twice.
  assign req     = (pend_q > {{(CNT_W-1){1'b0}}, gnt});
  assign full    = at_max;
  assign ovf_err = ovf_q;
  assign gnt_err = gerr_q;

`ifdef REQ_TRACK_STATS_EN
  assign gnt_taken = take;
`endif

endmodule

// File: rtl/req_pending_tracker.sv
// Per-channel pending-request tracker in front of a fixed-priority arbiter.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : req_pulse/gnt in, req out (slave modport)
//   err_clr   : clears all sticky error flags
//   full      : per-channel counter saturated
//   ovf_err   : per-channel sticky overflow
//   gnt_err   : per-channel sticky spurious grant
//   grant_cnt : total grants consumed, saturating; constant 0 unless the
//               REQ_TRACK_STATS_EN macro is defined
module req_pending_tracker
  import req_track_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  req_pending_tracker_if.slave bus,
  input  logic                 err_clr,
  output logic [NUM_REQ-1:0]   full,
  output logic [NUM_REQ-1:0]   ovf_err,
  output logic [NUM_REQ-1:0]   gnt_err,
  output logic [15:0]          grant_cnt
);

`ifdef REQ_TRACK_STATS_EN
  logic [NUM_REQ-1:0] gnt_taken;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_chan
    req_track_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .req_pulse (bus.req_pulse[i]),
      .gnt       (bus.gnt[i]),
      .err_clr   (err_clr),
      .req       (bus.req[i]),
      .full      (full[i]),
      .ovf_err   (ovf_err[i]),
      .gnt_err   (gnt_err[i])
`ifdef REQ_TRACK_STATS_EN
      ,
      .gnt_taken (gnt_taken[i])
`endif
    );
  end

`ifdef REQ_TRACK_STATS_EN
  logic [15:0] grant_cnt_q, grant_cnt_d;
  logic [16:0] grant_sum;

  always_comb begin
    grant_sum = {1'b0, grant_cnt_q};
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_sum = grant_sum + 17'(gnt_taken[i]);
    end
    grant_cnt_d = grant_sum[16] ? 16'hFFFF : grant_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign grant_cnt = grant_cnt_q;
`else
  assign grant_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_req_pending_tracker.sv
// Self-checking bench for req_pending_tracker: cycle model plus directed
// vectors with literal expectations.
module tb_req_pending_tracker;
  import req_track_pkg::*;

  localparam int N = 4;
  localparam int PMAX = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_clr = 1'b0;
  logic [3:0]  full, ovf_err, gnt_err;
  logic [15:0] grant_cnt;

  int n_cmp = 0;
  int n_err = 0;

  req_pending_tracker_if #(.NUM_REQ(N)) bus ();

  req_pending_tracker #(
    .NUM_REQ(N),
    .CNT_W  (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .err_clr  (err_clr),
    .full     (full),
    .ovf_err  (ovf_err),
    .gnt_err  (gnt_err),
    .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer counts, clamp at PMAX, sticky flags.
  int       m_pend[N];
  bit [3:0] m_ovf, m_gerr, ovf_set, gerr_set;
  int       m_grants;
  bit       model_valid = 1'b0;
  int       taken_v, nxt_v;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_ovf = '0;
      m_gerr = '0;
      m_grants = 0;
      model_valid = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        taken_v = (bus.gnt[i] && m_pend[i] > 0) ? 1 : 0;
        nxt_v = m_pend[i] + int'(bus.req_pulse[i]) - taken_v;
        ovf_set[i] = (nxt_v > PMAX);
        if (nxt_v > PMAX) nxt_v = PMAX;
        gerr_set[i] = bus.gnt[i] && (m_pend[i] == 0);
        m_pend[i] = nxt_v;
        m_grants += taken_v;
      end
      if (m_grants > 65535) m_grants = 65535;
      m_ovf  = err_clr ? ovf_set : (m_ovf | ovf_set);
      m_gerr = err_clr ? gerr_set : (m_gerr | gerr_set);
    end
  end

  logic [3:0]  e_req, e_full;
  logic [15:0] e_cnt;

  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < N; i++) begin
        e_req[i]  = (m_pend[i] > int'(bus.gnt[i]));
        e_full[i] = (m_pend[i] == PMAX);
      end
`ifdef REQ_TRACK_STATS_EN
      e_cnt = 16'(m_grants);
`else
      e_cnt = 16'h0;
`endif
      check("model_req", 16'(bus.req), 16'(e_req));
      check("model_full", 16'(full), 16'(e_full));
      check("model_ovf", 16'(ovf_err), 16'(m_ovf));
      check("model_gerr", 16'(gnt_err), 16'(m_gerr));
      check("model_gcnt", grant_cnt, e_cnt);
    end
  end

  task automatic drive(input logic [3:0] rp, input logic [3:0] g, input logic clr);
    bus.req_pulse = rp;
    bus.gnt = g;
    err_clr = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.req_pulse = '0;
    bus.gnt = '0;
    err_clr = 1'b0;
    #1;
  endtask

  function automatic logic [3:0] prio(input logic [3:0] r);
    if (r[3]) return 4'b1000;
    if (r[2]) return 4'b0100;
    if (r[1]) return 4'b0010;
    if (r[0]) return 4'b0001;
    return 4'b0000;
  endfunction

  logic [3:0]  gq[$];
  logic [3:0]  exp_order[4];
  logic [3:0]  g_cur, r_now;
  logic [15:0] g0;
  bit          done;

  initial begin
    bus.req_pulse = '0;
    bus.gnt = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state, req masked by gnt on empty channels
    check("rst_full", 16'(full), 16'h0);
    check("rst_ovf", 16'(ovf_err), 16'h0);
    check("rst_gerr", 16'(gnt_err), 16'h0);
    check("rst_gcnt", grant_cnt, 16'h0);
    drive(4'b0000, 4'b1111, 1'b0);
    check("rst_req", 16'(bus.req), 16'h0);
    tick();
    check("spur_all", 16'(gnt_err), 16'h000F);
    drive(4'b0000, 4'b0000, 1'b1);
    tick();
    check("clr_all", 16'(gnt_err), 16'h0);

    // Single pulse latency
    drive(4'b0001, 4'b0000, 1'b0);
    tick();
    check("pulse_req", 16'(bus.req), 16'h0001);

    // Grant hides last request in the same cycle
    drive(4'b0100, 4'b0000, 1'b0);
    tick();
    check("ch2_req", 16'(bus.req), 16'h0005);
    drive(4'b0000, 4'b0100, 1'b0);
    check("ch2_hide", 16'(bus.req), 16'h0001);
    tick();
    check("ch2_noerr", 16'(gnt_err), 16'h0);
    drive(4'b0000, 4'b0100, 1'b0);
    tick();
    check("ch2_empty", 16'(gnt_err), 16'h0004);
    drive(4'b0000, 4'b0001, 1'b1);
    tick();
    check("ch0_drain", 16'(bus.req), 16'h0);
    check("ch2_clr", 16'(gnt_err), 16'h0);

    // Saturation on channel 1
    for (int k = 1; k <= 8; k++) begin
      drive(4'b0010, 4'b0000, 1'b0);
      tick();
      check("sat_full", 16'(full), (k >= 7) ? 16'h0002 : 16'h0);
      check("sat_ovf", 16'(ovf_err), (k >= 8) ? 16'h0002 : 16'h0);
    end
    for (int k = 0; k < 7; k++) begin
      drive(4'b0000, 4'b0010, 1'b0);
      check("drain_req", 16'(bus.req), (k < 6) ? 16'h0002 : 16'h0);
      tick();
    end
    check("drain_full", 16'(full), 16'h0);
    check("drain_gerr", 16'(gnt_err), 16'h0);
    drive(4'b0000, 4'b0000, 1'b1);
    tick();
    check("ovf_clr", 16'(ovf_err), 16'h0);

    // Pulse and grant together leave count unchanged
    drive(4'b0010, 4'b0000, 1'b0);
    tick();
    drive(4'b0010, 4'b0010, 1'b0);
    check("both_hide", 16'(bus.req), 16'h0);
    tick();
    check("both_req", 16'(bus.req), 16'h0002);
    check("both_gerr", 16'(gnt_err), 16'h0);
    drive(4'b0000, 4'b0010, 1'b0);
    tick();
    check("both_drain", 16'(bus.req), 16'h0);

    // Spurious grant with pulse on empty channel
    drive(4'b0001, 4'b0001, 1'b0);
    tick();
    check("sp_pulse_err", 16'(gnt_err), 16'h0001);
    check("sp_pulse_req", 16'(bus.req), 16'h0001);
    drive(4'b0000, 4'b0001, 1'b1);
    tick();
    check("sp_pulse_clr", 16'(gnt_err), 16'h0);

    // Set wins over clear
    drive(4'b0000, 4'b1000, 1'b0);
    tick();
    check("ch3_gerr", 16'(gnt_err), 16'h0008);
    drive(4'b0000, 4'b1000, 1'b1);
    tick();
    check("set_wins", 16'(gnt_err), 16'h0008);
    drive(4'b0000, 4'b0000, 1'b1);
    tick();
    check("ch3_clr", 16'(gnt_err), 16'h0);

    // Closed loop with a registered fixed-priority arbiter
    g0 = grant_cnt;
    drive(4'b1111, 4'b0000, 1'b0);
    tick();
    g_cur = 4'b0000;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      drive(4'b0000, g_cur, 1'b0);
      r_now = bus.req;
      if (g_cur != 4'b0000) gq.push_back(g_cur);
      if (g_cur == 4'b0000 && r_now == 4'b0000 && gq.size() > 0) done = 1'b1;
      g_cur = prio(r_now);
      tick();
    end
    if (!done) check("loop_timeout", 16'h1, 16'h0);
    exp_order[0] = 4'b1000;
    exp_order[1] = 4'b0100;
    exp_order[2] = 4'b0010;
    exp_order[3] = 4'b0001;
    check("loop_ngnt", 16'(gq.size()), 16'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size()) check("loop_order", 16'(gq[i]), 16'(exp_order[i]));
    end
    check("loop_req", 16'(bus.req), 16'h0);
    check("loop_gerr", 16'(gnt_err), 16'h0);
`ifdef REQ_TRACK_STATS_EN
    check("loop_gcnt", grant_cnt - g0, 16'd4);
`else
    check("loop_gcnt", grant_cnt, 16'h0);
`endif

    // Mid-operation reset with pend = {3,0,5,1}
    drive(4'b1011, 4'b0000, 1'b0);
    tick();
    drive(4'b1010, 4'b0000, 1'b0);
    tick();
    drive(4'b1010, 4'b0000, 1'b0);
    tick();
    drive(4'b0010, 4'b0000, 1'b0);
    tick();
    drive(4'b0010, 4'b0000, 1'b0);
    tick();
    check("pre_rst_req", 16'(bus.req), 16'h000B);
    rst = 1'b1;
    drive(4'b1111, 4'b1111, 1'b0);
    tick();
    rst = 1'b0;
    check("mid_rst_req", 16'(bus.req), 16'h0);
    check("mid_rst_full", 16'(full), 16'h0);
    check("mid_rst_ovf", 16'(ovf_err), 16'h0);
    check("mid_rst_gerr", 16'(gnt_err), 16'h0);
    drive(4'b0000, 4'b1111, 1'b0);
    tick();
    check("mid_rst_empty", 16'(gnt_err), 16'h000F);
    drive(4'b0000, 4'b0000, 1'b1);
    tick();

    // Overflow set wins over clear
    for (int k = 0; k < 7; k++) begin
      drive(4'b0001, 4'b0000, 1'b0);
      tick();
    end
    drive(4'b0001, 4'b0000, 1'b0);
    tick();
    check("ovf0", 16'(ovf_err), 16'h0001);
    drive(4'b0001, 4'b0000, 1'b1);
    tick();
    check("ovf_set_wins", 16'(ovf_err), 16'h0001);
    drive(4'b0000, 4'b0000, 1'b1);
    tick();
    check("ovf0_clr", 16'(ovf_err), 16'h0);

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
